busca_instrucao: RTL and testbench

BUSCA_INSTRUCAO -- requirements
Module: busca_instrucao

---
 rtl/busca_instrucao.sv | 150 +++++++++++++++
 tb/tb_busca_instrucao.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/busca_instrucao.sv
// rtl/busca_instrucao.sv - instruction fetch stage with one-entry output register and redirect flush
module busca_instrucao #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [6:0]  opcode
);

  // FETCH: may issue a new request; WAIT: request outstanding, result wanted;
  // DROP: request outstanding but flushed by a redirect, result discarded.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [31:0] out_pc_q, out_pc_d;

  logic        slot_free;
  logic        req_c;
  logic [31:0] req_addr_c;
  logic        capture;
  logic [31:0] capture_addr;
  logic [31:0] redirect_target;
  logic        redirect_pc_unused;

  // The low two bits of the redirect target are forced to zero for word alignment.
  assign redirect_pc_unused = ^redirect_pc[1:0];
  assign redirect_target    = {redirect_pc[31:2], 2'b00};

  // The output register can take a new word if it is empty or being drained this cycle.
  assign slot_free = !out_valid_q || out_ready;

  // Next-state, memory request and output-register update logic.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    addr_d       = addr_q;
    req_c        = 1'b0;
    req_addr_c   = pc_q;
    capture      = 1'b0;
    capture_addr = pc_q;

    case (state_q)
      FETCH: begin
        // Only issue when the word can land; this keeps one request outstanding at most.
        req_c      = slot_free;
        req_addr_c = pc_q;
        if (req_c) begin
          pc_d = pc_q + 32'd4;
          if (imem_ack) begin
            capture      = !redirect;
            capture_addr = pc_q;
          end else begin
            addr_d  = pc_q;
            state_d = redirect ? DROP : WAIT;
          end
        end
      end
      WAIT: begin
        // Request and address held stable until the memory answers.
        req_c      = 1'b1;
        req_addr_c = addr_q;
        if (imem_ack) begin
          capture      = !redirect;
          capture_addr = addr_q;
          state_d      = FETCH;
        end else if (redirect) begin
          state_d = DROP;
        end
      end
      DROP: begin
        // The memory still owes us a response; absorb it without using the data.
        req_c      = 1'b1;
        req_addr_c = addr_q;
        if (imem_ack) begin
          state_d = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase

    // A redirect always wins over sequential pc advance.
    if (redirect) begin
      pc_d = redirect_target;
    end
  end

  // Output register: redirect flushes, capture loads, handshake empties.
  always_comb begin
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    if (redirect) begin
      out_valid_d = 1'b0;
    end else if (capture) begin
      out_valid_d = 1'b1;
      out_instr_d = imem_rdata;
      out_pc_d    = capture_addr;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FETCH;
      pc_q        <= PC_RESET;
      addr_q      <= 32'd0;
      out_valid_q <= 1'b0;
      out_instr_q <= 32'd0;
      out_pc_q    <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
    end
  end

  // The request is masked while reset is held so nothing is issued before release.
  assign imem_req  = rst_n && req_c;
  assign imem_addr = req_addr_c;
  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_pc    = out_pc_q;
  assign opcode    = out_instr_q[6:0];

endmodule

// File: tb/tb_busca_instrucao.sv
// tb/tb_busca_instrucao.sv - table-driven self-checking bench for busca_instrucao
module tb_busca_instrucao;

  logic        clk;
  logic        rst_n;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_ready;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [6:0]  opcode;

  logic        u2_req;
  logic [31:0] u2_addr;
  logic        u2_valid;
  logic [31:0] u2_instr;
  logic [31:0] u2_pc;
  logic [6:0]  u2_opcode;

  int checks;
  int failures;

  busca_instrucao dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_pc     (out_pc),
    .opcode     (opcode)
  );

  busca_instrucao #(.PC_RESET(32'hFFFF_FFF8)) dut_wrap (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (u2_req),
    .imem_addr  (u2_addr),
    .imem_ack   (1'b1),
    .imem_rdata (32'h0000_0013),
    .redirect   (1'b0),
    .redirect_pc(32'h0000_0000),
    .out_valid  (u2_valid),
    .out_ready  (1'b1),
    .out_instr  (u2_instr),
    .out_pc     (u2_pc),
    .opcode     (u2_opcode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_ov;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic ack, input logic [31:0] rdata, input logic rdy,
                              input logic redir, input logic [31:0] rpc,
                              input logic e_req, input logic [31:0] e_addr,
                              input logic e_ov, input logic [31:0] e_pc,
                              input logic [31:0] e_instr);
    vec_t v;
    v.ack = ack; v.rdata = rdata; v.rdy = rdy; v.redir = redir; v.rpc = rpc;
    v.e_req = e_req; v.e_addr = e_addr; v.e_ov = e_ov; v.e_pc = e_pc; v.e_instr = e_instr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic [31:0] exp_opc;

    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    imem_ack = 1'b0;
    imem_rdata = 32'd0;
    redirect = 1'b0;
    redirect_pc = 32'd0;
    out_ready = 1'b1;

    //              ack rdata          rdy redir rpc         req addr          ov  out_pc        out_instr
    vecs[0]  = mk(1, 32'h0000_0033, 1, 0, 32'h0,     1, 32'h0000_0000, 0, 32'h0,     32'h0);
    vecs[1]  = mk(1, 32'h0040_0033, 1, 0, 32'h0,     1, 32'h0000_0004, 1, 32'h0,     32'h0000_0033);
    vecs[2]  = mk(1, 32'h0080_0033, 1, 0, 32'h0,     1, 32'h0000_0008, 1, 32'h4,     32'h0040_0033);
    vecs[3]  = mk(0, 32'h0,         0, 0, 32'h0,     0, 32'h0,         1, 32'h8,     32'h0080_0033);
    vecs[4]  = mk(0, 32'h0,         0, 0, 32'h0,     0, 32'h0,         1, 32'h8,     32'h0080_0033);
    vecs[5]  = mk(1, 32'hFFFF_FFFF, 0, 0, 32'h0,     0, 32'h0,         1, 32'h8,     32'h0080_0033);
    vecs[6]  = mk(0, 32'h0,         0, 0, 32'h0,     0, 32'h0,         1, 32'h8,     32'h0080_0033);
    vecs[7]  = mk(0, 32'h0,         0, 0, 32'h0,     0, 32'h0,         1, 32'h8,     32'h0080_0033);
    vecs[8]  = mk(0, 32'h0,         1, 0, 32'h0,     1, 32'h0000_000C, 1, 32'h8,     32'h0080_0033);
    vecs[9]  = mk(0, 32'h0,         1, 0, 32'h0,     1, 32'h0000_000C, 0, 32'h0,     32'h0);
    vecs[10] = mk(0, 32'h0,         1, 0, 32'h0,     1, 32'h0000_000C, 0, 32'h0,     32'h0);
    vecs[11] = mk(0, 32'h0,         1, 0, 32'h0,     1, 32'h0000_000C, 0, 32'h0,     32'h0);
    vecs[12] = mk(1, 32'h00C0_0013, 1, 0, 32'h0,     1, 32'h0000_000C, 0, 32'h0,     32'h0);
    vecs[13] = mk(0, 32'h0,         1, 0, 32'h0,     1, 32'h0000_0010, 1, 32'hC,     32'h00C0_0013);
    vecs[14] = mk(1, 32'h0100_0033, 1, 0, 32'h0,     1, 32'h0000_0010, 0, 32'h0,     32'h0);
    vecs[15] = mk(0, 32'h0,         1, 0, 32'h0,     1, 32'h0000_0014, 1, 32'h10,    32'h0100_0033);
    vecs[16] = mk(0, 32'h0,         1, 1, 32'h103,   1, 32'h0000_0014, 0, 32'h0,     32'h0);
    vecs[17] = mk(0, 32'h0,         1, 0, 32'h0,     1, 32'h0000_0014, 0, 32'h0,     32'h0);
    vecs[18] = mk(0, 32'h0,         1, 0, 32'h0,     1, 32'h0000_0014, 0, 32'h0,     32'h0);
    vecs[19] = mk(1, 32'hDEAD_BEEF, 1, 0, 32'h0,     1, 32'h0000_0014, 0, 32'h0,     32'h0);
    vecs[20] = mk(1, 32'h0000_0067, 1, 0, 32'h0,     1, 32'h0000_0100, 0, 32'h0,     32'h0);
    vecs[21] = mk(1, 32'h0000_0073, 1, 1, 32'h200,   1, 32'h0000_0104, 1, 32'h100,   32'h0000_0067);
    vecs[22] = mk(1, 32'h0000_0037, 0, 0, 32'h0,     1, 32'h0000_0200, 0, 32'h0,     32'h0);
    vecs[23] = mk(0, 32'h0,         0, 1, 32'h300,   0, 32'h0,         1, 32'h200,   32'h0000_0037);
    vecs[24] = mk(0, 32'h0,         1, 1, 32'h400,   1, 32'h0000_0300, 0, 32'h0,     32'h0);
    vecs[25] = mk(0, 32'h0,         1, 1, 32'h501,   1, 32'h0000_0300, 0, 32'h0,     32'h0);
    vecs[26] = mk(1, 32'h0000_0BAD, 1, 0, 32'h0,     1, 32'h0000_0300, 0, 32'h0,     32'h0);
    vecs[27] = mk(0, 32'h0,         1, 0, 32'h0,     1, 32'h0000_0500, 0, 32'h0,     32'h0);

    // Reset state.
    @(negedge clk);
    #1;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_u2_req", {31'd0, u2_req}, 32'd0);

    // Table: inputs applied mid-cycle, outputs sampled 1 ns later.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst_n       = 1'b1;
      imem_ack    = vecs[i].ack;
      imem_rdata  = vecs[i].rdata;
      out_ready   = vecs[i].rdy;
      redirect    = vecs[i].redir;
      redirect_pc = vecs[i].rpc;
      #1;
      chk($sformatf("v%0d_req", i), {31'd0, imem_req}, {31'd0, vecs[i].e_req});
      chk($sformatf("v%0d_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_ov});
      if (vecs[i].e_req)
        chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_addr);
      if (vecs[i].e_ov) begin
        exp_opc = vecs[i].e_instr;
        chk($sformatf("v%0d_out_pc", i), out_pc, vecs[i].e_pc);
        chk($sformatf("v%0d_out_instr", i), out_instr, vecs[i].e_instr);
        chk($sformatf("v%0d_opcode", i), {25'd0, opcode}, {25'd0, exp_opc[6:0]});
      end
    end

    // Reset while WAIT is outstanding, with a stray ack during and after reset.
    @(negedge clk);
    rst_n = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 32'h1111_1113;
    redirect = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("arst_req", {31'd0, imem_req}, 32'd0);
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_out_pc", out_pc, 32'd0);
    @(negedge clk);
    #1;
    chk("arst_hold_req", {31'd0, imem_req}, 32'd0);
    chk("arst_hold_valid", {31'd0, out_valid}, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    imem_ack = 1'b0;
    #1;
    chk("rel_req", {31'd0, imem_req}, 32'd1);
    chk("rel_addr", imem_addr, 32'd0);
    chk("rel_valid", {31'd0, out_valid}, 32'd0);
    chk("u2_addr0", u2_addr, 32'hFFFF_FFF8);
    chk("u2_req0", {31'd0, u2_req}, 32'd1);

    @(negedge clk);
    #1;
    chk("late_ack_valid", {31'd0, out_valid}, 32'd0);
    chk("wait_addr", imem_addr, 32'd0);
    chk("u2_addr1", u2_addr, 32'hFFFF_FFFC);
    chk("u2_valid1", {31'd0, u2_valid}, 32'd1);
    chk("u2_pc1", u2_pc, 32'hFFFF_FFF8);

    @(negedge clk);
    #1;
    chk("u2_addr_wrap", u2_addr, 32'h0000_0000);
    chk("u2_pc2", u2_pc, 32'hFFFF_FFFC);
    chk("u2_opcode", {25'd0, u2_opcode}, 32'h0000_0013);

    @(negedge clk);
    #1;
    chk("u2_addr3", u2_addr, 32'h0000_0004);
    chk("u2_pc3", u2_pc, 32'h0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
